// File: rtl/rf_spi_responder.sv
// rf_spi_responder: SPI-slave model of the RF transceiver register interface.
// Short (6-bit) and long (LONG_AW-bit, aliased) register spaces, TX-complete
// interrupt after a TXNCON trigger, registered write-commit strobe.
// Optional macro RF_RESP_RX_INJECT_EN adds an RX byte-injection port that
// fills long 0x300-0x37F and raises RXIF (short 0x31 bit3).
module rf_spi_responder #(
    parameter int unsigned LONG_AW  = 10,
    parameter int unsigned TX_DELAY = 200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cs,
    input  logic       sck,
    input  logic       sdi,
    output logic       sdo,
    output logic       intr,
    output logic       wr_strobe,
    output logic       wr_long,
    output logic [9:0] wr_addr,
    output logic [7:0] wr_data
`ifdef RF_RESP_RX_INJECT_EN
    ,
    input  logic       rx_inj_valid,
    input  logic [7:0] rx_inj_data,
    input  logic       rx_inj_last,
    output logic       rx_inj_ready
`endif
);

    localparam int unsigned LONG_DEPTH   = 1 << LONG_AW;
    localparam logic [5:0]  ADDR_TXNCON  = 6'h1B;
    localparam logic [5:0]  ADDR_INTSTAT = 6'h31;

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA, S_DONE} state_e;

    state_e      state_q, state_d;
    logic [2:0]  cs_sync_q, sck_sync_q;
    logic [1:0]  sdi_sync_q;
    logic [3:0]  bit_cnt_q;
    logic [14:0] hdr_q;
    logic [6:0]  data_q;
    logic [9:0]  addr_q;
    logic        is_long_q, rw_q;
    logic [7:0]  rd_sr_q;
    logic        sdo_q;
    logic        wr_strobe_q, wr_long_q;
    logic [9:0]  wr_addr_q;
    logic [7:0]  wr_data_q;
    logic        tx_busy_q;
    logic [31:0] tx_cnt_q;
    logic [7:0]  sreg_q [64];
    logic [7:0]  lreg_q [LONG_DEPTH];

    logic        cs_s, sdi_s, cs_fall, sck_rise, sck_fall;
    logic        hdr_done, data_done;
    logic [15:0] hdr_new;
    logic        hdr_long, hdr_rw;
    logic [9:0]  hdr_addr;
    logic [7:0]  hdr_rd_data, wdata_new;
    logic        do_write, do_rdclr, tx_trig, tx_done;

    assign cs_s     = cs_sync_q[1];
    assign sdi_s    = sdi_sync_q[1];
    assign cs_fall  = cs_sync_q[2] & ~cs_sync_q[1];
    assign sck_rise = ~sck_sync_q[2] & sck_sync_q[1];
    assign sck_fall = sck_sync_q[2] & ~sck_sync_q[1];

    // Header bits are kept in arrival order: bit 0 (frame type) ends up as the MSB.
    assign hdr_new     = {hdr_q, sdi_s};
    assign hdr_long    = (bit_cnt_q == 4'd15);
    assign hdr_addr    = hdr_long ? hdr_new[14:5] : {4'h0, hdr_new[6:1]};
    assign hdr_rw      = hdr_long ? hdr_new[4] : hdr_new[0];
    assign hdr_rd_data = hdr_long ? lreg_q[hdr_addr[LONG_AW-1:0]] : sreg_q[hdr_addr[5:0]];
    assign wdata_new   = {data_q, sdi_s};

    assign do_write = data_done & rw_q;
    assign do_rdclr = data_done & ~rw_q & ~is_long_q & (addr_q[5:0] == ADDR_INTSTAT);
    assign tx_trig  = do_write & ~is_long_q & (addr_q[5:0] == ADDR_TXNCON) & wdata_new[0] & ~tx_busy_q;
    assign tx_done  = tx_busy_q & (tx_cnt_q == 32'd1);

    assign sdo       = sdo_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_long   = wr_long_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;

`ifdef RF_RESP_RX_INJECT_EN
    logic [6:0] inj_ptr_q;
    logic [9:0] inj_addr;
    logic       inj_fire;
    assign inj_addr     = {3'b110, inj_ptr_q};
    assign rx_inj_ready = (state_q != S_DATA) & ~sreg_q[ADDR_INTSTAT][3];
    assign inj_fire     = rx_inj_valid & rx_inj_ready;
    assign intr         = sreg_q[ADDR_INTSTAT][0] | sreg_q[ADDR_INTSTAT][3];
`else
    assign intr         = sreg_q[ADDR_INTSTAT][0];
`endif

    // Two-stage synchronisers plus one history stage for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_sync_q  <= '1;
            sck_sync_q <= '0;
            sdi_sync_q <= '0;
        end else begin
            cs_sync_q  <= {cs_sync_q[1:0], cs};
            sck_sync_q <= {sck_sync_q[1:0], sck};
            sdi_sync_q <= {sdi_sync_q[0], sdi};
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; cs high overrides everything and aborts the frame.
    always_comb begin
        state_d   = state_q;
        hdr_done  = 1'b0;
        data_done = 1'b0;
        case (state_q)
            S_IDLE: if (cs_fall) state_d = S_HDR;
            S_HDR: begin
                if (sck_rise && ((bit_cnt_q == 4'd7 && !hdr_new[7]) || bit_cnt_q == 4'd15)) begin
                    hdr_done = 1'b1;
                    state_d  = S_DATA;
                end
            end
            S_DATA: begin
                if (sck_rise && bit_cnt_q == 4'd7) begin
                    data_done = 1'b1;
                    state_d   = S_DONE;
                end
            end
            default: ;
        endcase
        if (cs_s) begin
            state_d   = S_IDLE;
            hdr_done  = 1'b0;
            data_done = 1'b0;
        end
    end

    // Serial datapath: header/data shift-in, header decode, read shift-out on sdo.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q <= '0;
            hdr_q     <= '0;
            data_q    <= '0;
            addr_q    <= '0;
            is_long_q <= 1'b0;
            rw_q      <= 1'b0;
            rd_sr_q   <= '0;
            sdo_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    bit_cnt_q <= '0;
                    hdr_q     <= '0;
                end
                S_HDR: if (sck_rise) begin
                    hdr_q     <= hdr_new[14:0];
                    bit_cnt_q <= hdr_done ? 4'd0 : bit_cnt_q + 4'd1;
                end
                S_DATA: if (sck_rise) begin
                    data_q    <= wdata_new[6:0];
                    bit_cnt_q <= bit_cnt_q + 4'd1;
                end
                default: ;
            endcase
            if (hdr_done) begin
                addr_q    <= hdr_addr;
                is_long_q <= hdr_long;
                rw_q      <= hdr_rw;
                rd_sr_q   <= hdr_rw ? 8'h00 : hdr_rd_data;
            end
            if (state_q == S_DATA && !cs_s) begin
                if (sck_fall) begin
                    sdo_q   <= rd_sr_q[7];
                    rd_sr_q <= {rd_sr_q[6:0], 1'b0};
                end
            end else begin
                sdo_q <= 1'b0;
            end
        end
    end

    // Committed-write report: one-cycle strobe with address/data held afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_strobe_q <= 1'b0;
            wr_long_q   <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            wr_strobe_q <= do_write;
            if (do_write) begin
                wr_long_q <= is_long_q;
                wr_addr_q <= addr_q;
                wr_data_q <= wdata_new;
            end
        end
    end

    // Register arrays and TX timer; later assignments win, so hardware flag
    // sets override the read-clear of INTSTAT in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg_q    <= '{default: '0};
            lreg_q    <= '{default: '0};
            tx_busy_q <= 1'b0;
            tx_cnt_q  <= '0;
`ifdef RF_RESP_RX_INJECT_EN
            inj_ptr_q <= '0;
`endif
        end else begin
            if (tx_busy_q) begin
                tx_cnt_q <= tx_cnt_q - 32'd1;
                if (tx_done) tx_busy_q <= 1'b0;
            end
            if (tx_trig) begin
                tx_busy_q <= 1'b1;
                tx_cnt_q  <= TX_DELAY;
            end
`ifdef RF_RESP_RX_INJECT_EN
            if (inj_fire) begin
                lreg_q[inj_addr[LONG_AW-1:0]] <= rx_inj_data;
                inj_ptr_q <= rx_inj_last ? 7'd0 : inj_ptr_q + 7'd1;
            end
`endif
            if (do_write) begin
                if (is_long_q)
                    lreg_q[addr_q[LONG_AW-1:0]] <= wdata_new;
                else if (addr_q[5:0] == ADDR_TXNCON && tx_busy_q)
                    sreg_q[ADDR_TXNCON] <= wdata_new | 8'h01;
                else
                    sreg_q[addr_q[5:0]] <= wdata_new;
            end
            if (do_rdclr) sreg_q[ADDR_INTSTAT] <= '0;
`ifdef RF_RESP_RX_INJECT_EN
            if (inj_fire && rx_inj_last) sreg_q[ADDR_INTSTAT][3] <= 1'b1;
`endif
            if (tx_done) begin
                sreg_q[ADDR_TXNCON][0]  <= 1'b0;
                sreg_q[ADDR_INTSTAT][0] <= 1'b1;
            end
        end
    end

endmodule

// File: doc/rf_spi_responder.md
Name: rf_spi_responder

Overview:
- Behavioural SPI-slave model of the RF transceiver register interface. It is the responder end of the SPI link driven by the radio-side SPI master.
- Decodes short (6-bit) and long (10-bit) address frames and maintains short and long register arrays.
- Returns read data on sdo and raises a TX-complete interrupt after a transmit trigger.
- Used in simulation and FPGA loopback builds in place of the physical radio.

Parameters:
- LONG_AW, 10, long-address register array address width (depth 2^LONG_AW bytes); long address bits above LONG_AW are ignored (aliased)
- TX_DELAY, 200, clk cycles from TXNTRIG write commit to interrupt assertion (min 1)

Ports:
- clk  in  1  system clock; all logic on posedge
- rst_n  in  1  asynchronous active-low reset
- cs  in  1  chip select from master, active low
- sck  in  1  SPI clock from master, mode 0, idle low
- sdi  in  1  master-to-responder serial data, MSB first
- sdo  out  1  responder-to-master serial data, MSB first
- intr  out  1  interrupt to master, active high
- wr_strobe  out  1  one-cycle pulse on every committed register write
- wr_long  out  1  qualifies wr_addr: 1 = long space, 0 = short space
- wr_addr  out  10  committed write address (short uses [5:0], upper bits 0)
- wr_data  out  8  committed write data

Behaviour:
- Synchronisation: cs, sck and sdi pass through 2-FF synchronisers, then edge detection. The master must hold each sck half-period for at least 4 clk cycles.
- Reset: sdo=0, intr=0, wr_strobe=0, wr_long=0, wr_addr=0, wr_data=0. All registers read 0. FSM returns to IDLE. Reset mid-transaction discards the transaction with no write.
- FSM states: IDLE, HDR, DATA, DONE.
  - IDLE -> HDR on synchronised cs falling. Bit counter is cleared.
- HDR: shift sdi on each sck rising edge.
  - Bit 0 = 0 selects a short frame: addr = bits[6:1], rw = bit 7 (1 = write). Header is 8 bits.
  - Bit 0 = 1 selects a long frame: addr = bits[10:1], rw = bit 11, bits 12-15 are don't-care. Header is 16 bits.
- HDR -> DATA on the last header rising edge.
  - For reads, the addressed byte is latched at that point.
  - sdo presents data bit 7 on the following sck falling edge, then shifts on each subsequent falling edge.
- DATA: 8 sck rising edges. On the 8th edge:
  - Write: the register is updated and wr_strobe pulses for exactly 1 cycle on the next clk, with wr_long/wr_addr/wr_data valid in the same cycle.
  - Read: no register update.
  - In both cases the FSM goes to DONE.
- DONE: further sck edges are ignored and sdo is held 0. No auto-increment.
- cs rising returns the FSM to IDLE from any state; sdo is forced 0 while cs is high.
  - Abort before the 8th data edge means no write and no side effects.
- Read-during-commit: write and read of the same address in back-to-back transactions; the read returns the new value.
- TX trigger: a committed write to short 0x1B with data bit0=1 starts a down-counter at TX_DELAY.
  - The counter reaches 0 after TX_DELAY cycles. Then short 0x31 bit0 (TXNIF) is set, short 0x1B bit0 self-clears, and intr=1 in that same cycle.
  - A re-trigger while the counter is running is ignored; the data is still written except bit0, which stays 1.
- Interrupt clear: a completed read of short 0x31 clears 0x31 to 0x00 and drops intr on the cycle after the 8th data edge.
  - If a TX completion coincides with that clear cycle, the completion wins: bit0 = 1 and intr stays 1.

Optional Feature:
- Macro: RF_RESP_RX_INJECT_EN.
- Enabled: adds ports rx_inj_valid in 1, rx_inj_data in 8, rx_inj_last in 1, rx_inj_ready out 1.
  - Bytes are written sequentially into long space from 0x300 (wrapping at 0x37F).
  - On rx_inj_last, short 0x31 bit3 (RXIF) is set and intr=1.
  - rx_inj_ready=0 while an SPI transaction is in DATA, and while RXIF=1.
  - Reading 0x31 clears RXIF as well.
- Disabled: ports absent, long 0x300-0x37F behave as plain registers, RXIF is never set.

Test Plan:
- Reset: rst_n=0 mid-frame -> sdo=0, intr=0, no wr_strobe; then a short read of 0x10 returns 0x00.
- Short write then read: write 0x3C to short 0x12 -> one wr_strobe with wr_long=0, wr_addr=0x012, wr_data=0x3C; a short read of 0x12 returns sdo bits 0x3C MSB first.
- Long write then read: write 0xA5 to long 0x2F0 -> wr_long=1, wr_addr=0x2F0; a long read returns 0xA5; a read of short 0x30 is unaffected (0x00).
- Abort: cs rises after 5 data bits of a write of 0xFF to short 0x05 -> no wr_strobe; a readback returns 0x00.
- TX interrupt: write 0x01 to short 0x1B -> intr=1 exactly TX_DELAY cycles after commit; a read of 0x31 returns 0x01 and intr=0 the next cycle; a read of 0x1B returns 0x00.
- Inject (macro on): inject 3 bytes 0x11, 0x22, 0x33 with last -> intr=1; long reads of 0x300-0x302 return 0x11, 0x22, 0x33; a read of 0x31 returns 0x08.
